// File: rtl/dmem_responder.sv
// Data-memory responder: word array behind a small store buffer.
// Same-cycle loads with per-byte forwarding; shared external write port.
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int SB_DEPTH    = 4,
    parameter int ADR_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             adr_v_i,
    input  logic [XLEN-1:0]  adr_i,
    input  logic             is_store_i,
    input  logic [XLEN-1:0]  store_data_i,
    input  logic [2:0]       access_size_i,
    output logic [XLEN-1:0]  load_data_o,
    output logic             misalign_o,
    input  logic             ext_we_i,
    input  logic [ADR_W-1:0] ext_adr_i,
    input  logic [XLEN-1:0]  ext_wdata_i,
    output logic             ext_ready_o,
    output logic             sb_empty_o,
    output logic             sb_full_o
);

    localparam int NB = 4;
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADR_W-1:0] idx;
        logic [XLEN-1:0]  data;
        logic [NB-1:0]    be;
    } sb_entry_t;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    sb_entry_t       sb     [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_vld;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic             sz_b, sz_h, sz_w;
    logic             bad;
    logic             enq;
    logic             drain;
    logic             ext_go;
    logic [ADR_W-1:0] idx;
    logic [NB-1:0]    new_be;
    logic [XLEN-1:0]  new_data;
    logic             unused_hi;

    assign unused_hi = ^adr_i[XLEN-1:ADR_W+2];

    assign idx  = adr_i[ADR_W+1:2];
    assign sz_b = (access_size_i == 3'b001);
    assign sz_h = (access_size_i == 3'b010);
    assign sz_w = (access_size_i == 3'b100);

    assign bad = ~(sz_b | sz_h | sz_w)
               | (sz_h & adr_i[0])
               | (sz_w & (adr_i[1:0] != 2'b00));

    assign misalign_o  = adr_v_i & bad;
    assign sb_empty_o  = (count == '0);
    assign sb_full_o   = (count == CW'(SB_DEPTH));
    assign ext_ready_o = ~sb_full_o;

    assign enq    = adr_v_i & is_store_i & ~bad;
    // Drain is suppressed during reset so discarded stores never land.
    assign drain  = reset_n & ~sb_empty_o & (sb_full_o | ~ext_we_i);
    assign ext_go = ext_we_i & ~sb_full_o;

    // Byte-enable and lane-replicated data for a new store entry.
    always_comb begin
        new_be   = '0;
        new_data = store_data_i;
        if (sz_b) begin
            new_be   = NB'(1) << adr_i[1:0];
            new_data = {4{store_data_i[7:0]}};
        end else if (sz_h) begin
            new_be   = adr_i[1] ? 4'b1100 : 4'b0011;
            new_data = {2{store_data_i[15:0]}};
        end else if (sz_w) begin
            new_be   = 4'b1111;
        end
    end

    // Load: array word with bytes overridden oldest-to-youngest by SB hits.
    always_comb begin
        logic [PW-1:0] pos;
        load_data_o = mem[idx];
        for (int k = 0; k < SB_DEPTH; k++) begin
            pos = rd_ptr + PW'(k);
            if (sb_vld[pos] && sb[pos].idx == idx) begin
                for (int b = 0; b < NB; b++) begin
                    if (sb[pos].be[b])
                        load_data_o[b*8 +: 8] = sb[pos].data[b*8 +: 8];
                end
            end
        end
    end

    // Store-buffer pointers, occupancy and entry storage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            sb_vld <= '0;
        end else begin
            if (drain) begin
                sb_vld[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (enq) begin
                sb_vld[wr_ptr] <= 1'b1;
                sb[wr_ptr]     <= '{idx: idx, data: new_data, be: new_be};
                wr_ptr         <= wr_ptr + 1'b1;
            end
            count <= count + CW'(enq) - CW'(drain);
        end
    end

    // Single array write port: buffer drain or external word write.
    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < NB; b++) begin
                if (sb[rd_ptr].be[b])
                    mem[sb[rd_ptr].idx][b*8 +: 8] <= sb[rd_ptr].data[b*8 +: 8];
            end
        end else if (ext_go) begin
            mem[ext_adr_i] <= ext_wdata_i;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Hand-computed expectations for forwarding, arbitration and reset.
module tb_dmem_responder;

    logic        clk = 0;
    logic        reset_n;
    logic        adr_v_i;
    logic [31:0] adr_i;
    logic        is_store_i;
    logic [31:0] store_data_i;
    logic [2:0]  access_size_i;
    logic [31:0] load_data_o;
    logic        misalign_o;
    logic        ext_we_i;
    logic [9:0]  ext_adr_i;
    logic [31:0] ext_wdata_i;
    logic        ext_ready_o;
    logic        sb_empty_o;
    logic        sb_full_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk(clk), .reset_n(reset_n),
        .adr_v_i(adr_v_i), .adr_i(adr_i),
        .is_store_i(is_store_i), .store_data_i(store_data_i),
        .access_size_i(access_size_i),
        .load_data_o(load_data_o), .misalign_o(misalign_o),
        .ext_we_i(ext_we_i), .ext_adr_i(ext_adr_i),
        .ext_wdata_i(ext_wdata_i), .ext_ready_o(ext_ready_o),
        .sb_empty_o(sb_empty_o), .sb_full_o(sb_full_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        adr_v_i = 0; is_store_i = 0; store_data_i = 0;
        adr_i = 0; access_size_i = 3'b100;
    endtask

    task automatic req(input logic st, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] sz);
        adr_v_i = 1; is_store_i = st; adr_i = a;
        store_data_i = d; access_size_i = sz;
        #1;
    endtask

    task automatic ext(input logic we, input logic [9:0] a,
                       input logic [31:0] d);
        ext_we_i = we; ext_adr_i = a; ext_wdata_i = d;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a,
                            input logic [31:0] exp);
        req(0, a, 0, 3'b100);
        check(tag, load_data_o, exp);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 10 && !sb_empty_o; i++) tick();
        check(tag, 32'(sb_empty_o), 32'd1);
    endtask

    initial begin
        reset_n = 0;
        idle();
        ext(0, 0, 0);
        tick(); tick();
        reset_n = 1;
        #1;
        check("rst_empty", 32'(sb_empty_o), 32'd1);
        check("rst_full", 32'(sb_full_o), 32'd0);
        check("rst_ready", 32'(ext_ready_o), 32'd1);
        check("rst_misal", 32'(misalign_o), 32'd0);

        // Preload via the external port.
        ext(1, 10'd3, 32'hDEADBEEF); tick();
        ext(1, 10'd0, 32'hCAFEF00D); tick();
        for (int i = 0; i < 3; i++) begin
            ext(1, 10'(20 + i), 32'hA0 + 32'(i)); tick();
        end
        ext(1, 10'd100, 32'h0BAD0BAD); tick();
        ext(0, 0, 0);
        load_chk("t1_load", 32'h0C, 32'hDEADBEEF);
        check("t1_empty", 32'(sb_empty_o), 32'd1);

        // Byte store forwarded before drain lands.
        req(1, 32'h0D, 32'h000000AB, 3'b001);
        tick();
        load_chk("t2_fwd", 32'h0C, 32'hDEADABEF);
        check("t2_nempty", 32'(sb_empty_o), 32'd0);
        tick();
        check("t2_empty", 32'(sb_empty_o), 32'd1);
        load_chk("t2_arr", 32'h0C, 32'hDEADABEF);

        // Fill buffer while ext port holds the write port.
        ext(1, 10'd100, 32'h0BAD0BAD);
        for (int i = 0; i < 4; i++) begin
            req(1, 32'h20 + 32'(4 * i), 32'h10000000 + 32'(i), 3'b100);
            tick();
        end
        req(1, 32'h30, 32'h10000004, 3'b100);
        check("t3_full", 32'(sb_full_o), 32'd1);
        check("t3_ready", 32'(ext_ready_o), 32'd0);
        tick();
        idle();
        ext(0, 0, 0);
        #1;
        check("t3_full2", 32'(sb_full_o), 32'd1);
        wait_empty("t3_drain");
        for (int i = 0; i < 5; i++)
            load_chk($sformatf("t3_w%0d", i), 32'h20 + 32'(4 * i),
                     32'h10000000 + 32'(i));
        load_chk("t3_ext", 32'h190, 32'h0BAD0BAD);

        // Two buffered stores to one word: youngest byte wins.
        ext(1, 10'd100, 32'h0BAD0BAD);
        req(1, 32'h14, 32'h11111111, 3'b100); tick();
        req(1, 32'h16, 32'h00002222, 3'b010); tick();
        load_chk("t4_fwd", 32'h14, 32'h22221111);
        idle();
        ext(0, 0, 0);
        wait_empty("t4_drain");
        load_chk("t4_arr", 32'h14, 32'h22221111);

        // Misalignment detection.
        req(1, 32'h02, 32'hFFFFFFFF, 3'b100);
        check("t5_misal", 32'(misalign_o), 32'd1);
        tick();
        idle(); #1;
        check("t5_empty", 32'(sb_empty_o), 32'd1);
        load_chk("t5_arr", 32'h00, 32'hCAFEF00D);
        req(0, 32'h15, 0, 3'b010);
        check("t5_half", 32'(misalign_o), 32'd1);
        req(0, 32'h15, 0, 3'b001);
        check("t5_byte", 32'(misalign_o), 32'd0);
        req(0, 32'h14, 0, 3'b011);
        check("t5_size", 32'(misalign_o), 32'd1);
        idle(); #1;
        check("t5_inval", 32'(misalign_o), 32'd0);

        // Reset discards buffered stores.
        ext(1, 10'd100, 32'h0BAD0BAD);
        for (int i = 0; i < 3; i++) begin
            req(1, 32'h50 + 32'(4 * i), 32'h77777777, 3'b100);
            tick();
        end
        idle();
        ext(0, 0, 0);
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
        check("t6_empty", 32'(sb_empty_o), 32'd1);
        for (int i = 0; i < 3; i++)
            load_chk($sformatf("t6_w%0d", i), 32'h50 + 32'(4 * i),
                     32'hA0 + 32'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
